// File: rtl/jtag_instr_data_regs_if.sv
// Strobe, scan-data and result bundle between the TAP controller (master)
// and the JTAG instruction/data register bank (slave).
interface jtag_instr_data_regs_if #(
    parameter int IR_WIDTH   = 5,
    parameter int USER_WIDTH = 32
);
    logic                  reset;
    logic                  tdi;
    logic                  captureIR;
    logic                  shiftIR;
    logic                  updateIR;
    logic                  captureDR;
    logic                  shiftDR;
    logic                  updateDR;
    logic                  select;
    logic                  tdo_en;
    logic [USER_WIDTH-1:0] user_capture;
    logic                  tdo;
    logic [IR_WIDTH-1:0]   instr;
    logic [USER_WIDTH-1:0] user_dr;
    logic                  user_update;

    modport master (
        output reset, tdi, captureIR, shiftIR, updateIR,
               captureDR, shiftDR, updateDR, select, tdo_en, user_capture,
        input  tdo, instr, user_dr, user_update
    );

    modport slave (
        input  reset, tdi, captureIR, shiftIR, updateIR,
               captureDR, shiftDR, updateDR, select, tdo_en, user_capture,
        output tdo, instr, user_dr, user_update
    );
endinterface

// File: rtl/jtag_instr_data_regs.sv
// JTAG IR plus BYPASS/IDCODE/USER data registers, clocked by TAP strobes.
// Optional `JTAG_USER_CAPTURE_EN: USER capture loads user_capture instead of user_dr.
module jtag_instr_data_regs #(
    parameter int          IR_WIDTH   = 5,
    parameter logic [31:0] IDCODE_VAL = 32'h0BA00477,
    parameter int          USER_WIDTH = 32
) (
    input logic                   tck,
    input logic                   trst,
    jtag_instr_data_regs_if.slave bus
);
    localparam int DR_WIDTH = (USER_WIDTH > 32) ? USER_WIDTH : 32;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IR_WIDTH-1:0] OP_USER    = OP_IDCODE << 1;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = OP_IDCODE;

    if (IDCODE_VAL[0] != 1'b1) begin : g_idcodeCheck
        $error("IDCODE_VAL bit 0 must be 1");
    end
    if (IR_WIDTH < 2) begin : g_irWidthCheck
        $error("IR_WIDTH must be at least 2");
    end

    logic [IR_WIDTH-1:0]   irSr_r;
    logic [IR_WIDTH-1:0]   instr_r;
    logic                  bypass_r;
    logic [DR_WIDTH-1:0]   drSr_r;
    logic [USER_WIDTH-1:0] userDr_r;
    logic                  userUpdate_r;

    logic                  isIdcode_s;
    logic                  isUser_s;
    logic                  isBypass_s;
    logic [USER_WIDTH-1:0] userSrc_s;
    logic [USER_WIDTH-1:0] userShifted_s;
    logic [DR_WIDTH-1:0]   drCapture_s;
    logic [DR_WIDTH-1:0]   drShift_s;
    logic                  tdo_s;

`ifdef JTAG_USER_CAPTURE_EN
    assign userSrc_s = bus.user_capture;
`else
    logic unusedCapture_s;
    assign userSrc_s       = userDr_r;
    assign unusedCapture_s = ^bus.user_capture;
`endif

    if (USER_WIDTH == 1) begin : g_userShift1
        assign userShifted_s = bus.tdi;
    end else begin : g_userShiftN
        assign userShifted_s = {bus.tdi, drSr_r[USER_WIDTH-1:1]};
    end

    // Instruction decode; anything not IDCODE or USER behaves as BYPASS.
    always_comb begin
        isIdcode_s = (instr_r == OP_IDCODE);
        isUser_s   = (instr_r == OP_USER);
        isBypass_s = !(isIdcode_s || isUser_s);
    end

    // Next dr_sr value for capture and shift of the selected data register.
    always_comb begin
        drCapture_s = {DR_WIDTH{1'b0}};
        drShift_s   = drSr_r;
        if (isIdcode_s) begin
            drCapture_s[31:0] = IDCODE_VAL;
            drShift_s[31:0]   = {bus.tdi, drSr_r[31:1]};
        end else if (isUser_s) begin
            drCapture_s[USER_WIDTH-1:0] = userSrc_s;
            drShift_s[USER_WIDTH-1:0]   = userShifted_s;
        end else begin
            drCapture_s = drSr_r;
        end
    end

    // Register bank; strobes act as clock enables in priority order.
    always_ff @(posedge tck) begin
        if (!trst) begin
            irSr_r       <= {IR_WIDTH{1'b0}};
            instr_r      <= OP_IDCODE;
            bypass_r     <= 1'b0;
            drSr_r       <= {DR_WIDTH{1'b0}};
            userDr_r     <= {USER_WIDTH{1'b0}};
            userUpdate_r <= 1'b0;
        end else if (bus.reset) begin
            instr_r      <= OP_IDCODE;
            irSr_r       <= {IR_WIDTH{1'b0}};
            userUpdate_r <= 1'b0;
        end else begin
            userUpdate_r <= 1'b0;
            if (bus.captureIR || bus.captureDR) begin
                if (bus.captureIR) begin
                    irSr_r <= IR_CAPTURE;
                end
                if (bus.captureDR) begin
                    drSr_r <= drCapture_s;
                    if (isBypass_s) begin
                        bypass_r <= 1'b0;
                    end
                end
            end else if (bus.shiftIR || bus.shiftDR) begin
                if (bus.shiftIR) begin
                    irSr_r <= {bus.tdi, irSr_r[IR_WIDTH-1:1]};
                end
                if (bus.shiftDR) begin
                    drSr_r <= drShift_s;
                    if (isBypass_s) begin
                        bypass_r <= bus.tdi;
                    end
                end
            end else begin
                if (bus.updateIR) begin
                    instr_r <= irSr_r;
                end
                if (bus.updateDR && isUser_s) begin
                    userDr_r     <= drSr_r[USER_WIDTH-1:0];
                    userUpdate_r <= 1'b1;
                end
            end
        end
    end

    // Serial output mux toward the pad logic.
    always_comb begin
        if (!bus.tdo_en) begin
            tdo_s = 1'b0;
        end else if (bus.select) begin
            tdo_s = irSr_r[0];
        end else if (isBypass_s) begin
            tdo_s = bypass_r;
        end else begin
            tdo_s = drSr_r[0];
        end
    end

    assign bus.tdo         = tdo_s;
    assign bus.instr       = instr_r;
    assign bus.user_dr     = userDr_r;
    assign bus.user_update = userUpdate_r;
endmodule

// File: tb/tb_jtag_instr_data_regs.sv
// Scoreboard bench for jtag_instr_data_regs: expected tdo bits are queued as
// stimulus is applied and popped as the DUT shifts them out.
module tb_jtag_instr_data_regs;
    localparam int          IRW    = 5;
    localparam int          UW     = 32;
    localparam logic [31:0] IDCODE = 32'h0BA00477;

    logic tck = 1'b0;
    logic trst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic expQ[$];
    logic [31:0] capExp;

    always #5 tck = ~tck;

    jtag_instr_data_regs_if #(.IR_WIDTH(IRW), .USER_WIDTH(UW)) bus ();

    jtag_instr_data_regs #(
        .IR_WIDTH  (IRW),
        .IDCODE_VAL(IDCODE),
        .USER_WIDTH(UW)
    ) dut (
        .tck (tck),
        .trst(trst),
        .bus (bus.slave)
    );

    task automatic idle();
        bus.reset     = 1'b0;
        bus.captureIR = 1'b0;
        bus.shiftIR   = 1'b0;
        bus.updateIR  = 1'b0;
        bus.captureDR = 1'b0;
        bus.shiftDR   = 1'b0;
        bus.updateDR  = 1'b0;
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic loadIr(input logic [IRW-1:0] op);
        bus.captureIR = 1'b1;
        step();
        bus.captureIR = 1'b0;
        bus.shiftIR   = 1'b1;
        for (int i = 0; i < IRW; i++) begin
            bus.tdi = op[i];
            step();
        end
        bus.shiftIR  = 1'b0;
        bus.updateIR = 1'b1;
        step();
        bus.updateIR = 1'b0;
    endtask

    task automatic test_reset();
        trst = 1'b0;
        step();
        trst = 1'b1;
        bus.tdo_en = 1'b1;
        bus.select = 1'b0;
        #1;
        vectors++;
        if (bus.instr !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_instr: got %b expected %b", bus.instr, 5'b00001);
        end
        vectors++;
        if (bus.user_dr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_user_dr: got %h expected %h", bus.user_dr, 32'h0);
        end
        vectors++;
        if (bus.user_update !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_user_update: got %b expected 0", bus.user_update);
        end
        vectors++;
        if (bus.tdo !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tdo: got %b expected 0", bus.tdo);
        end
        bus.tdo_en = 1'b0;
    endtask

    task automatic test_idcode();
        logic [31:0] v;
        logic        e;
        v = IDCODE;
        bus.captureDR = 1'b1;
        step();
        bus.captureDR = 1'b0;
        for (int i = 0; i < 32; i++) expQ.push_back(v[i]);
        for (int i = 0; i < 4; i++) expQ.push_back(1'b0);
        bus.tdo_en  = 1'b1;
        bus.tdi     = 1'b0;
        bus.shiftDR = 1'b1;
        for (int i = 0; i < 36; i++) begin
            #1;
            e = expQ.pop_front();
            vectors++;
            if (bus.tdo !== e) begin
                miscompares++;
                $display("FAIL idcode_bit%0d: got %b expected %b", i, bus.tdo, e);
            end
            step();
        end
        bus.shiftDR = 1'b0;
        bus.tdo_en  = 1'b0;
    endtask

    task automatic test_bypass();
        logic [7:0] pat;
        logic       e;
        pat = 8'hA5;
        bus.captureIR = 1'b1;
        step();
        bus.captureIR = 1'b0;
        bus.select    = 1'b1;
        bus.tdo_en    = 1'b1;
        bus.tdi       = 1'b1;
        bus.shiftIR   = 1'b1;
        expQ.push_back(1'b1);
        for (int i = 0; i < 4; i++) expQ.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            e = expQ.pop_front();
            vectors++;
            if (bus.tdo !== e) begin
                miscompares++;
                $display("FAIL ir_tdo_bit%0d: got %b expected %b", i, bus.tdo, e);
            end
            step();
        end
        bus.shiftIR  = 1'b0;
        bus.updateIR = 1'b1;
        step();
        bus.updateIR = 1'b0;
        bus.select   = 1'b0;
        vectors++;
        if (bus.instr !== 5'b11111) begin
            miscompares++;
            $display("FAIL bypass_instr: got %b expected %b", bus.instr, 5'b11111);
        end
        bus.captureDR = 1'b1;
        step();
        bus.captureDR = 1'b0;
        bus.shiftDR   = 1'b1;
        expQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.tdi = pat[i];
            #1;
            e = expQ.pop_front();
            vectors++;
            if (bus.tdo !== e) begin
                miscompares++;
                $display("FAIL bypass_bit%0d: got %b expected %b", i, bus.tdo, e);
            end
            expQ.push_back(pat[i]);
            step();
        end
        bus.shiftDR = 1'b0;
        #1;
        e = expQ.pop_front();
        vectors++;
        if (bus.tdo !== e) begin
            miscompares++;
            $display("FAIL bypass_last: got %b expected %b", bus.tdo, e);
        end
        bus.tdo_en = 1'b0;
    endtask

    task automatic test_user();
        logic [31:0] d;
        logic        e;
        d = 32'hDEADBEEF;
        loadIr(5'b00010);
        vectors++;
        if (bus.instr !== 5'b00010) begin
            miscompares++;
            $display("FAIL user_instr: got %b expected %b", bus.instr, 5'b00010);
        end
        bus.captureDR = 1'b1;
        step();
        bus.captureDR = 1'b0;
        bus.shiftDR   = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.tdi = d[i];
            step();
        end
        bus.shiftDR  = 1'b0;
        bus.updateDR = 1'b1;
        step();
        bus.updateDR = 1'b0;
        vectors++;
        if (bus.user_dr !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL user_dr: got %h expected %h", bus.user_dr, 32'hDEADBEEF);
        end
        vectors++;
        if (bus.user_update !== 1'b1) begin
            miscompares++;
            $display("FAIL user_update_hi: got %b expected 1", bus.user_update);
        end
        step();
        vectors++;
        if (bus.user_update !== 1'b0) begin
            miscompares++;
            $display("FAIL user_update_lo: got %b expected 0", bus.user_update);
        end
`ifdef JTAG_USER_CAPTURE_EN
        capExp = 32'h12345678;
`else
        capExp = 32'hDEADBEEF;
`endif
        bus.user_capture = 32'h12345678;
        bus.captureDR    = 1'b1;
        step();
        bus.captureDR = 1'b0;
        for (int i = 0; i < 32; i++) expQ.push_back(capExp[i]);
        bus.tdo_en  = 1'b1;
        bus.tdi     = 1'b0;
        bus.shiftDR = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            e = expQ.pop_front();
            vectors++;
            if (bus.tdo !== e) begin
                miscompares++;
                $display("FAIL user_capture_bit%0d: got %b expected %b", i, bus.tdo, e);
            end
            step();
        end
        bus.shiftDR = 1'b0;
        bus.tdo_en  = 1'b0;
        bus.captureDR = 1'b1;
        step();
        bus.captureDR = 1'b0;
        bus.updateDR  = 1'b1;
        step();
        bus.updateDR = 1'b0;
        vectors++;
        if (bus.user_dr !== capExp) begin
            miscompares++;
            $display("FAIL user_noshift_update: got %h expected %h", bus.user_dr, capExp);
        end
    endtask

    task automatic test_reset_mid();
        bus.captureDR = 1'b1;
        step();
        bus.captureDR = 1'b0;
        bus.shiftDR   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.tdi = 1'($urandom_range(1, 0));
            step();
        end
        bus.shiftDR = 1'b0;
        bus.reset   = 1'b1;
        step();
        bus.reset = 1'b0;
        vectors++;
        if (bus.instr !== 5'b00001) begin
            miscompares++;
            $display("FAIL midreset_instr: got %b expected %b", bus.instr, 5'b00001);
        end
        vectors++;
        if (bus.user_dr !== capExp) begin
            miscompares++;
            $display("FAIL midreset_user_dr: got %h expected %h", bus.user_dr, capExp);
        end
        vectors++;
        if (bus.user_update !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_user_update: got %b expected 0", bus.user_update);
        end
        bus.updateDR = 1'b1;
        step();
        bus.updateDR = 1'b0;
        vectors++;
        if (bus.user_update !== 1'b0 || bus.user_dr !== capExp) begin
            miscompares++;
            $display("FAIL midreset_update_ignored: got %b/%h expected 0/%h",
                     bus.user_update, bus.user_dr, capExp);
        end
    endtask

    task automatic test_tdo_en();
        bus.captureDR = 1'b1;
        step();
        bus.captureDR = 1'b0;
        bus.tdo_en    = 1'b0;
        bus.tdi       = 1'b0;
        bus.shiftDR   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.tdo !== 1'b0) begin
                miscompares++;
                $display("FAIL tdo_en_off_bit%0d: got %b expected 0", i, bus.tdo);
            end
            step();
        end
        bus.shiftDR = 1'b0;
        bus.tdo_en  = 1'b1;
        #1;
        vectors++;
        if (bus.tdo !== 1'b0) begin
            miscompares++;
            $display("FAIL tdo_en_advanced: got %b expected 0", bus.tdo);
        end
        bus.shiftDR = 1'b1;
        step();
        bus.shiftDR = 1'b0;
        #1;
        vectors++;
        if (bus.tdo !== 1'b1) begin
            miscompares++;
            $display("FAIL tdo_en_bit4: got %b expected 1", bus.tdo);
        end
        bus.tdo_en = 1'b0;
    endtask

    initial begin
        trst             = 1'b1;
        bus.tdi          = 1'b0;
        bus.select       = 1'b0;
        bus.tdo_en       = 1'b0;
        bus.user_capture = 32'h0;
        capExp           = 32'h0;
        idle();
        test_reset();
        test_idcode();
        test_bypass();
        test_user();
        test_reset_mid();
        test_tdo_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
